conv_layer_mem: RTL and testbench
=================================

CONV_LAYER_MEM -- requirements
Module: conv_layer_mem

Interface
REQ-001 The block SHALL have no parameters; bank depths are fixed: L0 banks 4096, L1 banks 1024, L2 bank 2048, all 20 bits wide.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cwr  input  1  write strobe from CONV.
REQ-005 caddr_wr  input  12  write address.
REQ-006 cdata_wr  input  20  write data.
REQ-007 crd  input  1  read strobe from CONV.
REQ-008 caddr_rd  input  12  read address.
REQ-009 csel  input  3  bank select: 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2; 000/110/111 invalid.
REQ-010 cdata_rd  output  20  registered read data.
REQ-011 err  output  1  sticky access-error flag.
REQ-012 wr_cnt0  output  13  saturating count of accepted writes to the L0 banks.
REQ-013 wr_cnt1  output  11  saturating count of accepted writes to the L1 banks.
REQ-014 wr_cnt2  output  12  saturating count of accepted writes to the L2 bank.

Function
REQ-015 Write: on a rising edge with cwr=1, valid csel and caddr_wr below the bank depth, the block SHALL store cdata_wr at caddr_wr in the selected bank.
REQ-016 Read: on a rising edge with crd=1, valid csel and in-range caddr_rd, cdata_rd SHALL take the stored word; latency is exactly 1 cycle.
REQ-017 cdata_rd SHALL hold its last value while crd=0.
REQ-018 Out-of-range access: caddr >= 1024 for L1 or >= 2048 for L2, or an invalid csel, SHALL discard the write, and a read SHALL load cdata_rd with 0; either case SHALL set err.
REQ-019 err SHALL stay at 1 until reset.
REQ-020 cwr=1 and crd=1 in the same cycle SHALL both be serviced, using the single csel for both.
REQ-021 Same-cycle same-address read/write collision SHALL follow REQ-031.
REQ-022 Each accepted write SHALL increment the counter of its layer by 1.
REQ-023 A counter at all-ones SHALL hold; rejected writes SHALL NOT count.
REQ-024 Stored data SHALL be treated as an opaque 20-bit pattern, with no arithmetic on it.

Reset
REQ-025 When reset=0, the block SHALL asynchronously force cdata_rd=0, err=0 and all wr_cnt outputs=0.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 An access whose edge coincides with reset=0 SHALL be discarded, including its write and counter update.
REQ-028 The first access SHALL be serviced on the first rising edge after reset deasserts.
REQ-029 Reset mid-run SHALL preserve previously written words.

Configuration
REQ-030 The macro SHALL be MEM_BYPASS_EN.
REQ-031 With MEM_BYPASS_EN defined, a same-cycle same-bank same-address read and write SHALL return cdata_wr (write-first).
REQ-032 With MEM_BYPASS_EN undefined, that collision SHALL return the previously stored word (read-first).
REQ-033 MEM_BYPASS_EN SHALL change no other behaviour.

Verification
REQ-034 Reset, then write csel=001 addr 0x000 data 0x12345, then read the same -> cdata_rd=0x12345 one cycle after crd; wr_cnt0=1; err=0.
REQ-035 Write csel=100 addr 0x3FF data 0xFFFFF, then write csel=100 addr 0x400 -> first stored, second discarded; err=1; wr_cnt1=1; reading 0x400 gives 0.
REQ-036 Collision, csel=101 addr 0x010 holding 0x00AAA, with cwr=crd=1 and cdata_wr 0x00BBB -> cdata_rd=0x00BBB with MEM_BYPASS_EN, 0x00AAA without it.
REQ-037 8192 writes to L0 banks (4096 with csel=001, 4096 with csel=010) -> wr_cnt0=8191 (saturated); a full read-back of both banks matches the written data.
REQ-038 Access with csel=110 -> write ignored, read returns 0, err=1.
REQ-039 After REQ-038, pulse reset low mid-sequence -> err=0, counters=0, cdata_rd=0; earlier L0 data still reads back unchanged.

Source files
------------

// File: rtl/conv_layer_mem.sv
// Layered feature-map memory for the CONV engine: five 20-bit banks with range checking, sticky error and per-layer write counters.
// Define MEM_BYPASS_EN for write-first same-address collisions; the default build is read-first.
module conv_layer_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [19:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    input  logic [2:0]  csel,
    output logic [19:0] cdata_rd,
    output logic        err,
    output logic [12:0] wr_cnt0,
    output logic [10:0] wr_cnt1,
    output logic [11:0] wr_cnt2
);

    localparam logic [2:0] SEL_L0K0 = 3'b001;
    localparam logic [2:0] SEL_L0K1 = 3'b010;
    localparam logic [2:0] SEL_L1K0 = 3'b011;
    localparam logic [2:0] SEL_L1K1 = 3'b100;
    localparam logic [2:0] SEL_L2   = 3'b101;

    logic [19:0] r_memL0K0 [0:4095];
    logic [19:0] r_memL0K1 [0:4095];
    logic [19:0] r_memL1K0 [0:1023];
    logic [19:0] r_memL1K1 [0:1023];
    logic [19:0] r_memL2   [0:2047];

    logic [19:0] r_cdataRd;
    logic        r_err;
    logic [12:0] r_wrCnt0;
    logic [10:0] r_wrCnt1;
    logic [11:0] r_wrCnt2;

    logic        w_wrOk;
    logic        w_rdOk;
    logic        w_accessErr;
    logic        w_wrL0;
    logic        w_wrL1;
    logic        w_wrL2;
    logic [19:0] w_rdData;

    function automatic logic inRange(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            SEL_L0K0, SEL_L0K1: inRange = 1'b1;
            SEL_L1K0, SEL_L1K1: inRange = (addr[11:10] == 2'b00);
            SEL_L2:             inRange = ~addr[11];
            default:            inRange = 1'b0;
        endcase
    endfunction

    // Writes are qualified by reset so an edge that lands while reset is low changes nothing.
    assign w_wrOk      = reset & cwr & inRange(csel, caddr_wr);
    assign w_rdOk      = crd & inRange(csel, caddr_rd);
    assign w_accessErr = (cwr & ~inRange(csel, caddr_wr)) | (crd & ~w_rdOk);
    assign w_wrL0      = w_wrOk & ((csel == SEL_L0K0) | (csel == SEL_L0K1));
    assign w_wrL1      = w_wrOk & ((csel == SEL_L1K0) | (csel == SEL_L1K1));
    assign w_wrL2      = w_wrOk & (csel == SEL_L2);

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_wrOk) begin
            case (csel)
                SEL_L0K0: r_memL0K0[caddr_wr]       <= cdata_wr;
                SEL_L0K1: r_memL0K1[caddr_wr]       <= cdata_wr;
                SEL_L1K0: r_memL1K0[caddr_wr[9:0]]  <= cdata_wr;
                SEL_L1K1: r_memL1K1[caddr_wr[9:0]]  <= cdata_wr;
                SEL_L2:   r_memL2[caddr_wr[10:0]]   <= cdata_wr;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_rdData = '0;
        case (csel)
            SEL_L0K0: w_rdData = r_memL0K0[caddr_rd];
            SEL_L0K1: w_rdData = r_memL0K1[caddr_rd];
            SEL_L1K0: w_rdData = r_memL1K0[caddr_rd[9:0]];
            SEL_L1K1: w_rdData = r_memL1K1[caddr_rd[9:0]];
            SEL_L2:   w_rdData = r_memL2[caddr_rd[10:0]];
            default:  w_rdData = '0;
        endcase
`ifdef MEM_BYPASS_EN
        // Both ports share csel, so an address match is a same-bank collision.
        if (w_wrOk && w_rdOk && (caddr_wr == caddr_rd)) begin
            w_rdData = cdata_wr;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cdataRd <= '0;
            r_err     <= 1'b0;
        end else begin
            if (crd) begin
                r_cdataRd <= w_rdOk ? w_rdData : 20'h00000;
            end
            if (w_accessErr) begin
                r_err <= 1'b1;
            end
        end
    end

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrCnt0 <= '0;
            r_wrCnt1 <= '0;
            r_wrCnt2 <= '0;
        end else begin
            if (w_wrL0 && (r_wrCnt0 != '1)) begin
                r_wrCnt0 <= r_wrCnt0 + 13'd1;
            end
            if (w_wrL1 && (r_wrCnt1 != '1)) begin
                r_wrCnt1 <= r_wrCnt1 + 11'd1;
            end
            if (w_wrL2 && (r_wrCnt2 != '1)) begin
                r_wrCnt2 <= r_wrCnt2 + 12'd1;
            end
        end
    end

    assign cdata_rd = r_cdataRd;
    assign err      = r_err;
    assign wr_cnt0  = r_wrCnt0;
    assign wr_cnt1  = r_wrCnt1;
    assign wr_cnt2  = r_wrCnt2;

endmodule

// File: tb/tb_conv_layer_mem.sv
// Directed bench for conv_layer_mem: reset, read/write, range errors, collision, counter saturation and reset retention.
// Collision expectation follows MEM_BYPASS_EN.
module tb_conv_layer_mem;

    logic        clk;
    logic        reset;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;
    logic [19:0] cdata_rd;
    logic        err;
    logic [12:0] wr_cnt0;
    logic [10:0] wr_cnt1;
    logic [11:0] wr_cnt2;

    int vectorsApplied = 0;
    int miscompares    = 0;

`ifdef MEM_BYPASS_EN
    localparam logic [19:0] COLLIDE_EXP = 20'h00BBB;
`else
    localparam logic [19:0] COLLIDE_EXP = 20'h00AAA;
`endif

    conv_layer_mem dut (
        .clk      (clk),
        .reset    (reset),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .csel     (csel),
        .cdata_rd (cdata_rd),
        .err      (err),
        .wr_cnt0  (wr_cnt0),
        .wr_cnt1  (wr_cnt1),
        .wr_cnt2  (wr_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] patL0K0(input logic [11:0] a);
        return {a, ~a[7:0]};
    endfunction

    function automatic logic [19:0] patL0K1(input logic [11:0] a);
        return {~a, a[7:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock of access; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic wr, input logic [11:0] waddr, input logic [19:0] wdata,
                                 input logic rd, input logic [11:0] raddr, input logic [2:0] sel);
        cwr      = wr;
        caddr_wr = waddr;
        cdata_wr = wdata;
        crd      = rd;
        caddr_rd = raddr;
        csel     = sel;
        @(posedge clk);
        #1;
        cwr = 1'b0;
        crd = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        cwr      = 1'b0;
        crd      = 1'b0;
        caddr_wr = '0;
        cdata_wr = '0;
        caddr_rd = '0;
        csel     = 3'b000;
        #2;
        reset = 1'b0;
        #2;
        checkOutput("rstCdata", 32'(cdata_rd), 32'h0);
        checkOutput("rstErr", 32'(err), 32'h0);
        checkOutput("rstCnt0", 32'(wr_cnt0), 32'h0);
        checkOutput("rstCnt1", 32'(wr_cnt1), 32'h0);
        checkOutput("rstCnt2", 32'(wr_cnt2), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] basic write/read on L0K0");
        applyStimulus(1'b1, 12'h000, 20'h12345, 1'b0, 12'h000, 3'b001);
        checkOutput("cnt0AfterWr", 32'(wr_cnt0), 32'd1);
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h000, 3'b001);
        checkOutput("rdL0K0Addr0", 32'(cdata_rd), 32'h12345);
        checkOutput("errClean", 32'(err), 32'h0);
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b0, 12'h001, 3'b010);
        checkOutput("holdNoRd", 32'(cdata_rd), 32'h12345);

        $display("[TB] L1 range boundary");
        applyStimulus(1'b1, 12'h3FF, 20'hFFFFF, 1'b0, 12'h000, 3'b100);
        checkOutput("cnt1Edge", 32'(wr_cnt1), 32'd1);
        checkOutput("errInRange", 32'(err), 32'h0);
        applyStimulus(1'b1, 12'h400, 20'h11111, 1'b0, 12'h000, 3'b100);
        checkOutput("errOutRange", 32'(err), 32'h1);
        checkOutput("cnt1Rejected", 32'(wr_cnt1), 32'd1);
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h3FF, 3'b100);
        checkOutput("rdL1K1Edge", 32'(cdata_rd), 32'hFFFFF);
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h400, 3'b100);
        checkOutput("rdL1K1Out", 32'(cdata_rd), 32'h0);

        $display("[TB] simultaneous read and write, different addresses");
        applyStimulus(1'b1, 12'h001, 20'h13579, 1'b0, 12'h000, 3'b011);
        applyStimulus(1'b1, 12'h002, 20'h2468A, 1'b1, 12'h001, 3'b011);
        checkOutput("rdWhileWr", 32'(cdata_rd), 32'h13579);
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h002, 3'b011);
        checkOutput("rdL1K0New", 32'(cdata_rd), 32'h2468A);
        checkOutput("cnt1Three", 32'(wr_cnt1), 32'd3);

        $display("[TB] L2 collision");
        applyStimulus(1'b1, 12'h010, 20'h00AAA, 1'b0, 12'h000, 3'b101);
        applyStimulus(1'b1, 12'h010, 20'h00BBB, 1'b1, 12'h010, 3'b101);
        checkOutput("collision", 32'(cdata_rd), 32'(COLLIDE_EXP));
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h010, 3'b101);
        checkOutput("rdAfterColl", 32'(cdata_rd), 32'h00BBB);
        checkOutput("cnt2Two", 32'(wr_cnt2), 32'd2);
        applyStimulus(1'b1, 12'h800, 20'h55555, 1'b0, 12'h000, 3'b101);
        checkOutput("cnt2Rejected", 32'(wr_cnt2), 32'd2);

        $display("[TB] L0 fill and saturation");
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(1'b1, a[11:0], patL0K0(a[11:0]), 1'b0, 12'h000, 3'b001);
        end
        checkOutput("cnt0Half", 32'(wr_cnt0), 32'd4097);
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(1'b1, a[11:0], patL0K1(a[11:0]), 1'b0, 12'h000, 3'b010);
        end
        checkOutput("cnt0Sat", 32'(wr_cnt0), 32'd8191);
        applyStimulus(1'b1, 12'hFFF, patL0K1(12'hFFF), 1'b0, 12'h000, 3'b010);
        checkOutput("cnt0Hold", 32'(wr_cnt0), 32'd8191);
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, a[11:0], 3'b001);
            checkOutput("rdBackL0K0", 32'(cdata_rd), 32'(patL0K0(a[11:0])));
        end
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, a[11:0], 3'b010);
            checkOutput("rdBackL0K1", 32'(cdata_rd), 32'(patL0K1(a[11:0])));
        end

        $display("[TB] reset clears flags before invalid-select test");
        reset = 1'b0;
        #2;
        checkOutput("rstAErr", 32'(err), 32'h0);
        checkOutput("rstACnt0", 32'(wr_cnt0), 32'h0);
        checkOutput("rstACdata", 32'(cdata_rd), 32'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h005, 3'b001);
        checkOutput("rdBeforeBad", 32'(cdata_rd), 32'(patL0K0(12'h005)));
        applyStimulus(1'b1, 12'h005, 20'h77777, 1'b1, 12'h005, 3'b110);
        checkOutput("badSelRd", 32'(cdata_rd), 32'h0);
        checkOutput("badSelErr", 32'(err), 32'h1);
        checkOutput("badSelCnt0", 32'(wr_cnt0), 32'h0);

        $display("[TB] reset mid-run with access on the edge");
        reset = 1'b0;
        #1;
        checkOutput("rstBCdata", 32'(cdata_rd), 32'h0);
        checkOutput("rstBErr", 32'(err), 32'h0);
        cwr      = 1'b1;
        caddr_wr = 12'h000;
        cdata_wr = 20'h00000;
        csel     = 3'b001;
        @(posedge clk);
        #1;
        cwr   = 1'b0;
        reset = 1'b1;
        checkOutput("rstBCnt0", 32'(wr_cnt0), 32'h0);
        checkOutput("rstBCnt1", 32'(wr_cnt1), 32'h0);
        checkOutput("rstBCnt2", 32'(wr_cnt2), 32'h0);
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h000, 3'b001);
        checkOutput("keepL0K0Addr0", 32'(cdata_rd), 32'(patL0K0(12'h000)));
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h005, 3'b001);
        checkOutput("keepL0K0Addr5", 32'(cdata_rd), 32'(patL0K0(12'h005)));
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'hABC, 3'b010);
        checkOutput("keepL0K1", 32'(cdata_rd), 32'(patL0K1(12'hABC)));
        applyStimulus(1'b0, 12'h000, 20'h00000, 1'b1, 12'h3FF, 3'b100);
        checkOutput("keepL1K1", 32'(cdata_rd), 32'hFFFFF);
        checkOutput("errAfterRst", 32'(err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
